// File: rtl/alu32_bist_pkg.sv
// Shared definitions for the alu32 self-test engine: op codes, FSM encoding,
// LFSR step and the alu32 reference model.
package alu32_bist_pkg;

  localparam logic [2:0] ALU_ADD = 3'h2;
  localparam logic [2:0] ALU_SUB = 3'h3;
  localparam logic [2:0] ALU_AND = 3'h4;
  localparam logic [2:0] ALU_OR  = 3'h5;
  localparam logic [2:0] ALU_NOR = 3'h6;
  localparam logic [2:0] ALU_XOR = 3'h7;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        neg;
  } alu_res_t;

  // Galois form, shifting right; taps folded in when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  endfunction

  function automatic logic [2:0] op_at(input logic [2:0] sel);
    logic [2:0] op;
    case (sel)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_SUB;
      3'd2:    op = ALU_AND;
      3'd3:    op = ALU_OR;
      3'd4:    op = ALU_NOR;
      3'd5:    op = ALU_XOR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic alu_res_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op);
    alu_res_t r;
    r.res = 32'h0;
    r.ovf = 1'b0;
    case (op)
      ALU_ADD: begin
        r.res = a + b;
        r.ovf = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      ALU_SUB: begin
        r.res = a - b;
        r.ovf = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      ALU_AND: r.res = a & b;
      ALU_OR:  r.res = a | b;
      ALU_NOR: r.res = ~(a | b);
      ALU_XOR: r.res = a ^ b;
      default: r.res = 32'h0;
    endcase
    r.zero = (r.res == 32'h0);
    r.neg  = r.res[31];
    return r;
  endfunction

endpackage

// File: rtl/alu32_bist_lfsr32.sv
// 32-bit Galois LFSR operand source; reloads its seed on reset or load_seed.
module alu32_bist_lfsr32
  import alu32_bist_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_seed,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] q_q;

  always_ff @(posedge clock) begin
    if (reset || load_seed) begin
      q_q <= seed;
    end else if (step) begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/alu32_bist.sv
// Hardware self-test for alu32: drives pseudo-random vectors, checks the
// combinational results against an inline reference model, reports a verdict.
module alu32_bist
  import alu32_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [31:0] SEED_A      = 32'h1234_5678,
  parameter logic [31:0] SEED_B      = 32'h8765_4321
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_negative,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] fail_count,
  output logic [15:0] first_fail_idx,
  output logic [1:0]  dbg_state_o
);

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);

  state_e      state_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [2:0]  ctl_q;
  logic        busy_q, done_q, pass_q;
  logic [15:0] fail_q, ffi_q, idx_q;
  logic [2:0]  op_sel_q;

  logic [31:0] lfsr_a, lfsr_b;
  logic        start_accept, lfsr_step;
  alu_res_t    model;
  logic        mismatch;

  // start is a request sampled only in IDLE; busy high means requests are dropped.
  assign start_accept = start && (state_q == ST_IDLE);
  assign lfsr_step    = (state_q == ST_DRIVE);

  alu32_bist_lfsr32 u_lfsr_a (
    .clock     (clock),
    .reset     (reset),
    .load_seed (start_accept),
    .step      (lfsr_step),
    .seed      (SEED_A_EFF),
    .q         (lfsr_a)
  );

  alu32_bist_lfsr32 u_lfsr_b (
    .clock     (clock),
    .reset     (reset),
    .load_seed (start_accept),
    .step      (lfsr_step),
    .seed      (SEED_B_EFF),
    .q         (lfsr_b)
  );

  always_comb begin
    model    = alu_ref(alu_a_q, alu_b_q, ctl_q);
    mismatch = (alu_out != model.res) || (alu_overflow != model.ovf) ||
               (alu_zero != model.zero) || (alu_negative != model.neg);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= 32'h0;
      alu_b_q  <= 32'h0;
      ctl_q    <= ALU_ADD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 16'h0;
      ffi_q    <= 16'hFFFF;
      idx_q    <= 16'h0;
      op_sel_q <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_DRIVE;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 16'h0;
            ffi_q    <= 16'hFFFF;
            idx_q    <= 16'h0;
            op_sel_q <= 3'd0;
          end
        end
        ST_DRIVE: begin
          alu_a_q <= lfsr_a;
          alu_b_q <= lfsr_b;
          ctl_q   <= op_at(op_sel_q);
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (fail_q != 16'hFFFF) fail_q <= fail_q + 16'd1;
            if (fail_q == 16'h0)    ffi_q  <= idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= ST_FIN;
          end else begin
            idx_q    <= idx_q + 16'd1;
            op_sel_q <= (op_sel_q == 3'd5) ? 3'd0 : op_sel_q + 3'd1;
            state_q  <= ST_DRIVE;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (fail_q == 16'h0);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_A          = alu_a_q;
  assign alu_B          = alu_b_q;
  assign alu_control    = ctl_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_idx = ffi_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_alu32_bist.sv
// Directed bench for alu32_bist: a bench-side alu32 with injectable faults,
// two engine instances (default 64-vector run, and a 6-vector run with SEED_A=0).
module tb_alu32_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start0, start1;
  logic [1:0] fault0;

  logic [31:0] a0, b0, out0, a1, b1, out1;
  logic [2:0]  c0, c1;
  logic        ov0, z0, n0, ov1, z1, n1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] fc0, ffi0, fc1, ffi1;
  logic [1:0]  st0, st1;
  logic [34:0] r0, r1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ea [64];
  logic [31:0] eb [64];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] m_lfsr(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ 32'h8020_0003) : (q >> 1);
  endfunction

  // fault: 0 correct, 1 ADD overflow stuck at 0, 2 NOR returns XOR
  function automatic logic [34:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic [1:0] fault);
    logic [31:0] s;
    logic        v;
    s = 32'h0;
    v = 1'b0;
    case (op)
      3'h2: begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); if (fault == 2'd1) v = 1'b0; end
      3'h3: begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
      3'h4: s = a & b;
      3'h5: s = a | b;
      3'h6: s = (fault == 2'd2) ? (a ^ b) : ~(a | b);
      3'h7: s = a ^ b;
      default: s = 32'h0;
    endcase
    return {s[31], (s == 32'h0), v, s};
  endfunction

  assign r0 = m_alu(a0, b0, c0, fault0);
  assign {n0, z0, ov0, out0} = r0;
  assign r1 = m_alu(a1, b1, c1, 2'd0);
  assign {n1, z1, ov1, out1} = r1;

  alu32_bist #(.NUM_VECTORS(64)) u_dut0 (
    .clock(clk), .reset(reset), .start(start0),
    .alu_A(a0), .alu_B(b0), .alu_control(c0),
    .alu_out(out0), .alu_overflow(ov0), .alu_zero(z0), .alu_negative(n0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .first_fail_idx(ffi0), .dbg_state_o(st0)
  );

  alu32_bist #(.NUM_VECTORS(6), .SEED_A(32'h0)) u_dut1 (
    .clock(clk), .reset(reset), .start(start1),
    .alu_A(a1), .alu_B(b1), .alu_control(c1),
    .alu_out(out1), .alu_overflow(ov1), .alu_zero(z1), .alu_negative(n1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_idx(ffi1), .dbg_state_o(st1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulses start on dut0 and counts busy cycles until done; extra_at re-pulses start mid-run.
  task automatic run0(input int extra_at, output int cyc);
    @(negedge clk);
    start0 = 1'b1;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start0 = (i == extra_at);
      if (busy0) cyc++;
      if (done0) break;
    end
    start0 = 1'b0;
  endtask

  initial begin
    int cyc;
    int exp_cnt;
    int exp_first;
    logic [31:0] qa, qb, s, eb1_2;

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; fault0 = 2'd0;

    qa = 32'h1234_5678;
    qb = 32'h8765_4321;
    for (int k = 0; k < 64; k++) begin
      ea[k] = qa; eb[k] = qb;
      qa = m_lfsr(qa); qb = m_lfsr(qb);
    end
    eb1_2 = m_lfsr(m_lfsr(32'h8765_4321));

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_alu_A", a0, 32'h0);
    check("rst_alu_B", b0, 32'h0);
    check("rst_ctl", 32'(c0), 32'h2);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_done", 32'(done0), 32'h0);
    check("rst_pass", 32'(pass0), 32'h0);
    check("rst_fail_count", 32'(fc0), 32'h0);
    check("rst_first_fail", 32'(ffi0), 32'hFFFF);
    reset = 1'b0;

    // Full run against a correct alu32
    run0(-1, cyc);
    check("t1_busy_cycles", 32'(cyc), 32'd129);
    check("t1_done", 32'(done0), 32'h1);
    check("t1_busy_low", 32'(busy0), 32'h0);
    check("t1_pass", 32'(pass0), 32'h1);
    check("t1_fail_count", 32'(fc0), 32'h0);
    check("t1_first_fail", 32'(ffi0), 32'hFFFF);

    // ADD overflow stuck at 0
    exp_cnt = 0;
    exp_first = 16'hFFFF;
    for (int k = 0; k < 64; k += 6) begin
      s = ea[k] + eb[k];
      if ((ea[k][31] == eb[k][31]) && (s[31] != ea[k][31])) begin
        if (exp_cnt == 0) exp_first = k;
        exp_cnt++;
      end
    end
    do_reset();
    fault0 = 2'd1;
    run0(-1, cyc);
    check("t2_done", 32'(done0), 32'h1);
    check("t2_fail_count", 32'(fc0), 32'(exp_cnt));
    check("t2_first_fail", 32'(ffi0), 32'(exp_first));
    check("t2_pass", 32'(pass0), (exp_cnt == 0) ? 32'h1 : 32'h0);

    // NOR answered with XOR: indices 4,10,...,58 all fail
    do_reset();
    fault0 = 2'd2;
    run0(-1, cyc);
    check("t3_done", 32'(done0), 32'h1);
    check("t3_fail_count", 32'(fc0), 32'd10);
    check("t3_first_fail", 32'(ffi0), 32'd4);
    check("t3_pass", 32'(pass0), 32'h0);

    // A second start mid-run is ignored
    do_reset();
    fault0 = 2'd0;
    run0(7, cyc);
    check("t4_busy_cycles", 32'(cyc), 32'd129);
    check("t4_pass", 32'(pass0), 32'h1);

    // Reset in CHECK of vector 10, then replay from seeds
    do_reset();
    @(negedge clk);
    start0 = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    check("t5_state_check", 32'(st0), 32'd2);
    check("t5_alu_A_v10", a0, ea[10]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_rst_alu_A", a0, 32'h0);
    check("t5_rst_ctl", 32'(c0), 32'h2);
    check("t5_rst_busy", 32'(busy0), 32'h0);
    check("t5_rst_state", 32'(st0), 32'd0);
    check("t5_rst_first_fail", 32'(ffi0), 32'hFFFF);
    exp_q = {ea[0], ea[1], ea[2]};
    @(negedge clk);
    start0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (i % 2 == 1) check("t5_replay_alu_A", a0, exp_q.pop_front());
    end
    for (int i = 0; i < 300; i++) begin
      if (done0) break;
      @(negedge clk);
    end
    check("t5_replay_done", 32'(done0), 32'h1);

    // SEED_A=0 instance: six vectors
    @(negedge clk);
    start1 = 1'b1;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (busy1) cyc++;
      if (i == 1) begin
        check("t6_first_alu_A", a1, 32'h1);
        check("t6_first_alu_B", b1, 32'h8765_4321);
      end
      if (i == 5) begin
        check("t6_and_ctl", 32'(c1), 32'h4);
        check("t6_and_alu_A", a1, 32'hC030_0002);
        check("t6_and_zero", 32'(z1), ((32'hC030_0002 & eb1_2) == 32'h0) ? 32'h1 : 32'h0);
      end
      if (done1) break;
    end
    check("t6_busy_cycles", 32'(cyc), 32'd13);
    check("t6_pass", 32'(pass1), 32'h1);
    check("t6_fail_count", 32'(fc1), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
